// File: rtl/gh_pkg.sv
// Shared Guitar Hero definitions: colour codes returned to the RGB mux,
// per-note judgement status and the lane play/title state.
package gh_pkg;

  localparam logic [1:0] CLR_NONE   = 2'b00;
  localparam logic [1:0] CLR_ACTIVE = 2'b01;
  localparam logic [1:0] CLR_HIT    = 2'b10;
  localparam logic [1:0] CLR_MISS   = 2'b11;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    HIT    = 2'd1,
    MISSED = 2'd2
  } note_status_t;

  typedef enum logic {
    TITLE = 1'b0,
    PLAY  = 1'b1
  } lane_state_t;

  function automatic logic [1:0] status_color(input note_status_t st);
    case (st)
      ACTIVE:  return CLR_ACTIVE;
      HIT:     return CLR_HIT;
      MISSED:  return CLR_MISS;
      default: return CLR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/note_lane_if.sv
// Bundle between the game top level and one colour lane: controls and
// pixel position in, colour code and score pulses out.
interface note_lane_if;
  import gh_pkg::*;

  logic        start;
  logic        press;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic [7:0]  shift;
  logic [31:0] speedshift;
  logic [1:0]  color;
  logic        hit_pulse;
  logic        miss_pulse;

  modport master (
    output start, press, hCount, vCount, shift, speedshift,
    input  color, hit_pulse, miss_pulse
  );

  modport slave (
    input  start, press, hCount, vCount, shift, speedshift,
    output color, hit_pulse, miss_pulse
  );

endinterface

// File: rtl/note_tick_gen.sv
// Speed divider shared by the lanes and the background scroller: one tick
// every (BASE_DIV - speedshift) enabled cycles, never faster than every cycle.
module note_tick_gen #(
  parameter int unsigned BASE_DIV = 250000
) (
  input  logic        clk,
  input  logic        resetbtn,
  input  logic        en,
  input  logic [31:0] speedshift,
  output logic        tick
);

  localparam logic [31:0] BASE = BASE_DIV;

  logic [31:0] threshold;
  logic [31:0] count;
  logic [32:0] count_inc;

  // Saturate so an oversized speedshift gives a tick every cycle instead of wrapping.
  always_comb begin
    threshold = 32'd1;
    if (speedshift < BASE && (BASE - speedshift) > 32'd1)
      threshold = BASE - speedshift;
  end

  assign count_inc = {1'b0, count} + 33'd1;
  assign tick      = en && (count_inc >= {1'b0, threshold});

  always_ff @(posedge clk or posedge resetbtn) begin
    if (resetbtn)
      count <= '0;
    else if (tick)
      count <= '0;
    else if (en)
      count <= count + 32'd1;
  end

endmodule

// File: rtl/note_lane.sv
// One colour lane: moves NUM_NOTES falling notes, judges presses against
// the hit window and returns a registered per-pixel colour code.
module note_lane #(
  parameter int          LANE_X    = 340,
  parameter int          NOTE_W    = 30,
  parameter int          NOTE_H    = 30,
  parameter int          NUM_NOTES = 4,
  parameter int          SPACING   = 195,
  parameter int          HIT_TOP   = 400,
  parameter int          HIT_BOT   = 455,
  parameter int          WRAP_Y    = 779,
  parameter int unsigned BASE_DIV  = 250000
) (
  input  logic       clk,
  input  logic       resetbtn,
  note_lane_if.slave lane
);
  import gh_pkg::*;

  localparam logic [9:0] HIT_TOP_Y = 10'(HIT_TOP);
  localparam logic [9:0] HIT_BOT_Y = 10'(HIT_BOT);
  localparam logic [9:0] WRAP_Y_Y  = 10'(WRAP_Y);

  lane_state_t  state;
  logic         playing;
  logic         tick;
  logic [9:0]   note_y  [NUM_NOTES];
  note_status_t note_st [NUM_NOTES];
  logic [NUM_NOTES-1:0] in_win;
  logic [NUM_NOTES-1:0] pix_on;
  logic [NUM_NOTES-1:0] escape_vec;
  logic         hit_found;
  logic [2:0]   hit_idx;
  logic [9:0]   best_y;
  logic         do_hit;
  logic         do_miss;
  logic [1:0]   color_next;
  logic [10:0]  lane_left;
  logic [10:0]  lane_right;
  logic [10:0]  h_pos;
  logic [10:0]  v_pos;

  always_ff @(posedge clk or posedge resetbtn) begin
    if (resetbtn)
      state <= TITLE;
    else if (state == TITLE && lane.start)
      state <= PLAY;
    else if (state == PLAY && !lane.start)
      state <= TITLE;
  end

  assign playing = (state == PLAY);

  note_tick_gen #(.BASE_DIV(BASE_DIV)) u_tick (
    .clk        (clk),
    .resetbtn   (resetbtn),
    .en         (playing),
    .speedshift (lane.speedshift),
    .tick       (tick)
  );

  // Score the lowest note on screen first; strict '>' keeps the lowest index on ties.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    best_y    = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (note_st[i] == ACTIVE && in_win[i] && (!hit_found || note_y[i] > best_y)) begin
        hit_found = 1'b1;
        hit_idx   = 3'(i);
        best_y    = note_y[i];
      end
    end
  end

  assign do_hit  = playing && lane.press && hit_found;
  assign do_miss = (playing && lane.press && !hit_found) || (|escape_vec);

  assign lane_left  = 11'(LANE_X) + {3'b000, lane.shift};
  assign lane_right = lane_left + 11'(NOTE_W - 1);
  assign h_pos      = {1'b0, lane.hCount};
  assign v_pos      = {1'b0, lane.vCount};

  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_note
    localparam logic [9:0] INIT_Y = 10'((g * SPACING) % (WRAP_Y + 1));

    logic [9:0]   y_q;
    note_status_t st_q;
    logic         at_wrap;
    logic         scored;
    logic [10:0]  note_bot;

    assign at_wrap       = (y_q == WRAP_Y_Y);
    assign scored        = do_hit && (hit_idx == 3'(g));
    // A press on the same cycle the note leaves the window takes precedence.
    assign escape_vec[g] = tick && (st_q == ACTIVE) && (y_q == HIT_BOT_Y) && !scored;
    assign in_win[g]     = (y_q >= HIT_TOP_Y) && (y_q <= HIT_BOT_Y);
    assign note_bot      = {1'b0, y_q} + 11'(NOTE_H - 1);
    assign pix_on[g]     = (h_pos >= lane_left) && (h_pos <= lane_right) &&
                           (v_pos >= {1'b0, y_q}) && (v_pos <= note_bot);

    always_ff @(posedge clk or posedge resetbtn) begin
      if (resetbtn) begin
        y_q  <= INIT_Y;
        st_q <= ACTIVE;
      end else if (tick) begin
        y_q <= at_wrap ? '0 : y_q + 10'd1;
        if (at_wrap)
          st_q <= ACTIVE;
        else if (scored)
          st_q <= HIT;
        else if (escape_vec[g])
          st_q <= MISSED;
      end else if (scored) begin
        st_q <= HIT;
      end
    end

    assign note_y[g]  = y_q;
    assign note_st[g] = st_q;
  end

  // Walk from the highest index down so the lowest overlapping note paints last.
  always_comb begin
    color_next = CLR_NONE;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (pix_on[i])
        color_next = status_color(note_st[i]);
    end
    if (!playing)
      color_next = CLR_NONE;
  end

  always_ff @(posedge clk or posedge resetbtn) begin
    if (resetbtn) begin
      lane.color      <= CLR_NONE;
      lane.hit_pulse  <= 1'b0;
      lane.miss_pulse <= 1'b0;
    end else begin
      lane.color      <= color_next;
      lane.hit_pulse  <= do_hit;
      lane.miss_pulse <= do_miss;
    end
  end

endmodule

// File: doc/note_lane.md
# note_lane

Parametrised single-lane note track for the Guitar Hero VGA game. It holds up to `NUM_NOTES` falling notes and advances them from a shared speed divider. It judges debounced button presses against a fixed hit window and returns a per-pixel colour code to the top-level RGB mux. Scores and misses are emitted as one-cycle pulses to the score counter; one instance sits in each colour lane.

## Interface
- `LANE_X`, 340: left pixel column of the lane before `shift` is added
- `NOTE_W`, 30: note width in pixels
- `NOTE_H`, 30: note height in pixels
- `NUM_NOTES`, 4: notes in flight per lane, range 1..8
- `SPACING`, 195: initial vertical gap between consecutive notes
- `HIT_TOP`, 400: top of the hit window (note Y, inclusive)
- `HIT_BOT`, 455: bottom of the hit window (note Y, inclusive)
- `WRAP_Y`, 779: Y value at which a note wraps back to 0
- `BASE_DIV`, 250000: clock cycles per 1-pixel step when `speedshift` = 0
---
- `clk` in 1: system clock
- `resetbtn` in 1: asynchronous active-high reset
- `start` in 1: level input (Sw0); leaves TITLE when high
- `press` in 1: single-cycle debounced button pulse (SCEN from an external debouncer)
- `hCount`, `vCount` in 10 each: current VGA pixel
- `shift` in 8: horizontal lane offset
- `speedshift` in 32: subtracted from `BASE_DIV`
- `color` out 2: 00 none, 01 active note, 10 hit note, 11 missed note
- `hit_pulse` out 1: one-cycle score pulse
- `miss_pulse` out 1: one-cycle miss pulse

## Operation
- FSM states:
  - TITLE: notes frozen, `color` = 00. Goes to PLAY when `start` = 1.
  - PLAY: notes move and are judged. Goes back to TITLE when `start` = 0, with positions held.
- Reset sets: state TITLE; note i at Y = i·SPACING mod (WRAP_Y+1); all statuses ACTIVE; divider 0; all outputs 0.
- Divider: threshold = `BASE_DIV` − `speedshift`, saturated to a minimum of 1. It counts only in PLAY. When count+1 ≥ threshold it issues `tick` and clears to 0.
- On `tick`, every note's Y increments by 1. A note at `WRAP_Y` goes to 0 instead and its status returns to ACTIVE.
- A note is in the window when HIT_TOP ≤ Y ≤ HIT_BOT.
- `press` in PLAY:
  - If any ACTIVE note is in the window, the one with the largest Y (ties: lowest index) becomes HIT and `hit_pulse` = 1. Only one note is scored per press.
  - Otherwise `miss_pulse` = 1 and no status changes.
- Escape: an ACTIVE note whose Y steps from HIT_BOT to HIT_BOT+1 becomes MISSED and raises `miss_pulse`.
- Simultaneous events:
  - A press and an escape of the same note in one cycle: the press wins (HIT, no miss).
  - A press-miss and an escape of a different note in one cycle: a single `miss_pulse`.
  - A hit and an escape of a different note in one cycle: both pulses assert.
- Pixel test for note i: LANE_X+shift ≤ hCount ≤ LANE_X+shift+NOTE_W−1 and Y ≤ vCount ≤ Y+NOTE_H−1. Do the arithmetic at 11 bits so nothing overflows.
- Colour by status: ACTIVE 01, HIT 10, MISSED 11. Where notes overlap, the lowest index wins. Outside all notes, 00.
- `press` in TITLE is ignored.

## Timing
- `color` is registered: 1-cycle latency from `hCount`/`vCount`. The top level delays sync by one cycle to match.
- `hit_pulse` / `miss_pulse` assert the cycle after `press` or `tick`, and last exactly 1 cycle.
- Back-to-back presses on consecutive cycles are each judged against status already updated by the previous press.
- `resetbtn` mid-frame clears all outputs immediately (asynchronously). The first `tick` comes at the earliest `threshold` cycles after reset release plus entry to PLAY.

## Structure
- Shared package `gh_pkg`:
  - colour codes `CLR_NONE`/`CLR_ACTIVE`/`CLR_HIT`/`CLR_MISS`
  - note status enum ACTIVE/HIT/MISSED
  - lane FSM enum TITLE/PLAY
- Sub-module `note_tick_gen`: the 32-bit divider with saturated threshold; ports `clk`, `resetbtn`, `en`, `speedshift`, `tick`. It is reused by other lanes and the background scroller.
- Note Y and status are arrays indexed 0..NUM_NOTES−1, filled by generate loops; priority selection is a for-loop.

## Test plan
- Reset with defaults → Y = {0,195,390,585}, `color` = 00, pulses 0; `start` = 1 with `BASE_DIV` = 4 → every Y increments every 4 cycles.
- Note 2 at Y = 400 plus `press` → `hit_pulse` for 1 cycle, status HIT, `color` = 10 at pixel (340, 400).
- `press` with no note in the window → `miss_pulse` = 1 and statuses unchanged; `press` in TITLE → no pulse.
- ACTIVE note steps 455→456 → `miss_pulse` once and `color` = 11. A press on that same cycle → `hit_pulse` only.
- Note at Y = 779 plus `tick` → Y = 0 and status ACTIVE; `speedshift` = 300000 → threshold saturates at 1, so a tick every cycle.
- `resetbtn` pulse mid-PLAY → outputs 0 within the same cycle, Y values restored, state TITLE.
